// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the MLP layers: default formats, FSM encodings and
// saturation helper.
package nn_fixed_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefFrac  = 4;
  localparam int unsigned One      = 1 << DefFrac;
  localparam int unsigned Half     = One >> 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StCapt = 3'd2;
  localparam logic [2:0] StBias = 3'd3;
  localparam logic [2:0] StAct  = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  // Clamp x to the signed range of a w-bit value.
  function automatic logic signed [31:0] sat_width(input logic signed [31:0] x,
                                                   input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/nn_act_hsigmoid.sv
// Combinational hard-sigmoid: y = clamp((z >>> 2) + 0.5, 0, 1.0) in the layer's Q format.
module nn_act_hsigmoid
  import nn_fixed_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned FRAC  = DefFrac
) (
  input  logic [WIDTH-1:0] i_z,
  output logic [WIDTH-1:0] o_y
);

  localparam int OneL  = 1 << FRAC;
  localparam int HalfL = 1 << (FRAC - 1);

  // One guard bit so the +HALF offset cannot overflow before clamping.
  logic signed [WIDTH:0] w_t;

  always_comb begin
    w_t = (WIDTH+1)'(signed'(i_z) >>> 2) + (WIDTH+1)'(HalfL);
    if (w_t[WIDTH]) begin
      o_y = '0;
    end else if (w_t > (WIDTH+1)'(OneL)) begin
      o_y = WIDTH'(OneL);
    end else begin
      o_y = w_t[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/nn_output_layer.sv
// Output layer of the fixed-point MLP: serially reads hidden activations, computes
// sum(w*a)+b per neuron, applies hard-sigmoid and holds the results behind a req/ack handshake.
module nn_output_layer
  import nn_fixed_pkg::*;
#(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned FRAC  = DefFrac,
  localparam int unsigned AddrW    = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned MemDepth = N_OUT * N_IN + N_OUT,
  localparam int unsigned MemAw    = (MemDepth > 1) ? $clog2(MemDepth) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req,
  output logic                   o_ack_layer,
  output logic                   o_rd_trig,
  output logic [AddrW-1:0]       o_rd_addr,
  input  logic [WIDTH-1:0]       i_rd_data,
  input  logic                   i_w_we,
  input  logic [MemAw-1:0]       i_w_addr,
  input  logic [WIDTH-1:0]       i_w_data,
  output logic [N_OUT*WIDTH-1:0] o_out_value
);

  localparam int unsigned JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned AccW = WIDTH + $clog2(N_IN) + FRAC;
  localparam logic [AddrW-1:0] ILast = AddrW'(N_IN - 1);
  localparam logic [JW-1:0]    JLast = JW'(N_OUT - 1);

  logic [2:0]               r_state;
  logic [AddrW-1:0]         r_i;
  logic [JW-1:0]            r_j;
  logic signed [AccW-1:0]   r_acc;
  logic [WIDTH-1:0]         r_z;
  logic [N_OUT*WIDTH-1:0]   r_out;
  logic signed [WIDTH-1:0]  r_coef [MemDepth];

  logic [MemAw-1:0]         w_widx;
  logic [MemAw-1:0]         w_bidx;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [AccW-1:0]   w_term;
  logic signed [31:0]       w_sum;
  logic [WIDTH-1:0]         w_hs;
  logic                     w_coef_we;

  always_comb begin
    w_widx = MemAw'(32'(r_j) * N_IN + 32'(r_i));
    w_bidx = MemAw'(N_OUT * N_IN + 32'(r_j));
    w_prod = (2*WIDTH)'(signed'(i_rd_data)) * (2*WIDTH)'(r_coef[w_widx]);
    w_term = AccW'(w_prod >>> FRAC);
    w_sum  = 32'(r_acc) + 32'(r_coef[w_bidx]);
    // Coefficients may only change while the layer is fully idle.
    w_coef_we = i_w_we && !i_req && (r_state == StIdle) &&
                ({1'b0, i_w_addr} < (MemAw+1)'(MemDepth));
  end

  nn_act_hsigmoid #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_act (
    .i_z (r_z),
    .o_y (w_hs)
  );

  always_ff @(posedge i_clk) begin
    if (w_coef_we) begin
      r_coef[i_w_addr] <= signed'(i_w_data);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_i     <= '0;
      r_j     <= '0;
      r_acc   <= '0;
      r_z     <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_acc <= '0;
          r_i   <= '0;
          r_j   <= '0;
          if (i_req) r_state <= StReq;
        end
        StReq: r_state <= StCapt;
        StCapt: begin
          r_acc <= r_acc + w_term;
          if (r_i == ILast) begin
            r_i     <= '0;
            r_state <= StBias;
          end else begin
            r_i     <= r_i + 1'b1;
            r_state <= StReq;
          end
        end
        StBias: begin
          r_z     <= WIDTH'(sat_width(w_sum, WIDTH));
          r_state <= StAct;
        end
        StAct: begin
          r_out[r_j*WIDTH +: WIDTH] <= w_hs;
          r_acc <= '0;
          r_i   <= '0;
          if (r_j == JLast) begin
            r_j     <= '0;
            r_state <= StDone;
          end else begin
            r_j     <= r_j + 1'b1;
            r_state <= StReq;
          end
        end
        StDone: if (!i_req) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rd_trig   = (r_state == StReq);
  assign o_ack_layer = (r_state == StDone);
  assign o_rd_addr   = r_i;
  assign o_out_value = r_out;

endmodule

// File: tb/tb_nn_output_layer.sv
// Scoreboard bench for nn_output_layer: stimulus queues expected results, a monitor checks
// each ack (value, latency, read-channel usage, ack width).
module tb_nn_output_layer;

  typedef struct {
    int out;
    int width;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       ack;
  logic       rd_trig;
  logic [0:0] rd_addr;
  logic [7:0] rd_data;
  logic       w_we;
  logic [1:0] w_addr;
  logic [7:0] w_data;
  logic [7:0] out_value;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   req_cyc = 0;
  int   trig_cnt = 0;
  int   addr_log [4];
  logic [7:0] act [2];
  logic       prev_trig = 1'b0;
  logic [0:0] prev_addr = 1'b0;
  logic       ack_prev = 1'b0;
  int   ack_w = 0;
  sb_t  sb [$];
  sb_t  cur;

  nn_output_layer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .o_ack_layer (ack),
    .o_rd_trig   (rd_trig),
    .o_rd_addr   (rd_addr),
    .i_rd_data   (rd_data),
    .i_w_we      (w_we),
    .i_w_addr    (w_addr),
    .i_w_data    (w_data),
    .o_out_value (out_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Activation source: data is valid only in the cycle after a trigger, junk otherwise.
  always @(negedge clk) begin
    if (prev_trig) rd_data = act[prev_addr];
    else rd_data = 8'h5A;
    if (rd_trig) begin
      if (trig_cnt < 4) addr_log[trig_cnt] = int'(rd_addr);
      trig_cnt++;
    end
    prev_trig = rd_trig;
    prev_addr = rd_addr;
  end

  always @(negedge clk) begin
    if (ack && !ack_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 1, 0);
        cur.width = 0;
      end else begin
        cur = sb.pop_front();
        chk("out_value", int'(out_value), cur.out);
        chk("latency", cyc - req_cyc, 7);
        chk("trig_count", trig_cnt, 2);
        chk("trig_addr_seq", addr_log[0] * 16 + addr_log[1], 1);
      end
      ack_w = 0;
    end
    if (ack) ack_w++;
    if (!ack && ack_prev) chk("ack_width", ack_w, cur.width);
    ack_prev = ack;
  end

  task automatic wr(input int a, input int d);
    @(posedge clk);
    #1 w_we = 1'b1;
    w_addr = 2'(a);
    w_data = 8'(d);
    @(posedge clk);
    #1 w_we = 1'b0;
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    int n = 0;
    while (ack !== lvl && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(ack), int'(lvl));
  endtask

  // mode 0: normal; 1: write attempted together with req; 2: req dropped and write while busy
  task automatic run(input int a0, input int a1, input int exp_out, input int mode);
    sb_t e;
    act[0] = 8'(a0);
    act[1] = 8'(a1);
    e.out = exp_out;
    e.width = (mode == 2) ? 1 : 2;
    sb.push_back(e);
    @(posedge clk);
    #1 req = 1'b1;
    req_cyc = cyc;
    trig_cnt = 0;
    if (mode == 1) begin
      w_we = 1'b1;
      w_addr = 2'd0;
      w_data = 8'd127;
    end
    if (mode == 2) begin
      repeat (2) @(posedge clk);
      #1 req = 1'b0;
      w_we = 1'b1;
      w_addr = 2'd0;
      w_data = 8'd127;
    end
    @(posedge clk);
    #1 w_we = 1'b0;
    wait_ack(1'b1, "ack_rise");
    if (mode != 2) begin
      @(posedge clk);
      #1 req = 1'b0;
    end
    wait_ack(1'b0, "ack_fall");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req = 1'b0;
    w_we = 1'b0;
    w_addr = '0;
    w_data = '0;
    act[0] = '0;
    act[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_trig", int'(rd_trig), 0);
    chk("rst_addr", int'(rd_addr), 0);
    chk("rst_out", int'(out_value), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    wr(0, 16); wr(1, -16); wr(2, 0);
    run(16, 0, 12, 0);
    run(16, 16, 8, 0);

    wr(0, 127); wr(1, 127);
    run(127, 127, 16, 0);

    // Reset in the second CAPT cycle, then a clean rerun.
    act[0] = 8'd127;
    act[1] = 8'd127;
    @(posedge clk);
    #1 req = 1'b1;
    trig_cnt = 0;
    repeat (4) @(posedge clk);
    #1 chk("mid_trigs", trig_cnt, 2);
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ack", int'(ack), 0);
    chk("mid_rst_trig", int'(rd_trig), 0);
    chk("mid_rst_out", int'(out_value), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(127, 127, 16, 0);

    wr(0, -128); wr(1, -128); wr(2, -128);
    run(127, 127, 0, 0);

    wr(0, 16); wr(1, -16); wr(2, 0);
    run(16, 0, 12, 1);
    run(16, 0, 12, 2);
    wr(2, -8);
    run(16, 0, 10, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
